// File: rtl/time_tag_capture_if.sv
// Read port of the time-tag FIFO: first-word-fall-through valid/ready with tag and source flags.
interface time_tag_capture_if #(
  parameter int CW = 28
);
  logic          rd_valid;
  logic          rd_ready;
  logic [CW-1:0] rd_data;
  logic [1:0]    rd_src;

  modport master (output rd_valid, output rd_data, output rd_src, input rd_ready);
  modport slave  (input rd_valid, input rd_data, input rd_src, output rd_ready);
endinterface

// File: rtl/time_tag_capture.sv
// Samples the free-running time-tag counter on event/PPS rising edges, queues the tags
// in a small FWFT FIFO and measures the counter delta between successive PPS edges.
module time_tag_capture #(
  parameter int CW          = 28,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic [CW-1:0]            count,
  input  logic                     evt_in,
  input  logic                     pps_in,
  time_tag_capture_if.master       rd,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic [CW-1:0]            pps_period,
  output logic                     pps_pvalid
);
  localparam int AW = $clog2(DEPTH);

  logic [SYNC_STAGES-1:0] evt_sync_reg, pps_sync_reg;
  logic [1:0]             evt_edge_reg, pps_edge_reg;
  logic                   evt_det, pps_det, capture;
  logic [1:0]             src;

  logic [CW+1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
  logic [CW+1:0] head_reg, head_next;
  logic          ovf_reg;
  logic          rd_valid_int, full, pop, push, drop;

  logic [CW-1:0] last_pps_reg, period_reg;
  logic          have_pps_reg, pvalid_reg;

  // Edge register is a two-deep delay of the last sync stage, so detection lands at SYNC_STAGES+1.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      evt_sync_reg <= '0;
      pps_sync_reg <= '0;
      evt_edge_reg <= '0;
      pps_edge_reg <= '0;
    end else begin
      evt_sync_reg <= {evt_sync_reg[SYNC_STAGES-2:0], evt_in};
      pps_sync_reg <= {pps_sync_reg[SYNC_STAGES-2:0], pps_in};
      evt_edge_reg <= {evt_edge_reg[0], evt_sync_reg[SYNC_STAGES-1]};
      pps_edge_reg <= {pps_edge_reg[0], pps_sync_reg[SYNC_STAGES-1]};
    end
  end

  assign evt_det = evt_edge_reg[0] & ~evt_edge_reg[1];
  assign pps_det = pps_edge_reg[0] & ~pps_edge_reg[1];
  assign capture = evt_det | pps_det;
  assign src     = {pps_det, evt_det};

  assign level        = wr_ptr_reg - rd_ptr_reg;
  assign rd_valid_int = (wr_ptr_reg != rd_ptr_reg);
  assign full         = (level == (AW+1)'(DEPTH));
  assign pop          = rd_valid_int & rd.rd_ready;
  assign push         = capture & (~full | pop);
  assign drop         = capture & full & ~pop;
  assign wr_ptr_next  = wr_ptr_reg + (AW+1)'(push);
  assign rd_ptr_next  = rd_ptr_reg + (AW+1)'(pop);

  // Head register tracks the entry the read pointer will point at; a tag landing in an
  // empty FIFO bypasses the array so it shows up in the very next cycle.
  always_comb begin
    head_next = head_reg;
    if (wr_ptr_next != rd_ptr_next) begin
      if (rd_ptr_next == wr_ptr_reg) head_next = {src, count};
      else                           head_next = mem[rd_ptr_next[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= {src, count};
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      head_reg     <= '0;
      ovf_reg      <= 1'b0;
      last_pps_reg <= '0;
      period_reg   <= '0;
      have_pps_reg <= 1'b0;
      pvalid_reg   <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      head_reg   <= head_next;
      if (drop)         ovf_reg <= 1'b1;
      else if (ovf_clr) ovf_reg <= 1'b0;
      // Period is tracked independently of whether the FIFO had room for this PPS.
      if (pps_det) begin
        last_pps_reg <= count;
        have_pps_reg <= 1'b1;
        if (have_pps_reg) begin
          period_reg <= count - last_pps_reg;
          pvalid_reg <= 1'b1;
        end
      end
    end
  end

  assign rd.rd_valid = rd_valid_int;
  assign rd.rd_data  = head_reg[CW-1:0];
  assign rd.rd_src   = head_reg[CW+1:CW];
  assign ovf         = ovf_reg;
  assign pps_period  = period_reg;
  assign pps_pvalid  = pvalid_reg;
endmodule
